// File: rtl/out_stretch.sv
// rtl/out_stretch.sv - three-channel event stretcher with registered glitch-free outputs
// Each rising event holds its output high for HOLD cycles; retriggers restart the window.
module out_stretch #(
  parameter int unsigned HOLD = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic e1,
  input  logic e2,
  input  logic e3,
  output logic q1,
  output logic q2,
  output logic q3,
  output logic any_active
);

  localparam int CW = $clog2(HOLD + 1);
  localparam logic [CW-1:0] HOLD_V = CW'(HOLD);
  localparam logic [CW-1:0] ONE_V  = CW'(1);

  logic [2:0]    e_vec;
  logic [2:0]    prev;
  logic [2:0]    rise;
  logic [2:0]    q_r;
  logic [2:0]    q_nxt;
  logic [CW-1:0] cnt     [3];
  logic [CW-1:0] cnt_nxt [3];
  logic          any_r;

  assign e_vec = {e3, e2, e1};

  always_comb begin
    rise  = '0;
    q_nxt = q_r;
    for (int i = 0; i < 3; i++) begin
      cnt_nxt[i] = cnt[i];
      rise[i]    = e_vec[i] & ~prev[i];
      if (rise[i]) begin
        cnt_nxt[i] = HOLD_V;
        q_nxt[i]   = 1'b1;
      end else if (cnt[i] != '0) begin
        if (cnt[i] == ONE_V) begin
          cnt_nxt[i] = '0;
          q_nxt[i]   = 1'b0;
        end else begin
          cnt_nxt[i] = cnt[i] - ONE_V;
        end
      end
    end
  end

  // prev resets high so a level already asserted at reset release never fires
  always_ff @(posedge clk) begin
    if (reset) begin
      prev  <= 3'b111;
      q_r   <= '0;
      any_r <= 1'b0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      prev  <= e_vec;
      q_r   <= q_nxt;
      any_r <= |q_nxt;
      for (int i = 0; i < 3; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  assign q1         = q_r[0];
  assign q2         = q_r[1];
  assign q3         = q_r[2];
  assign any_active = any_r;

endmodule

// File: tb/tb_out_stretch.sv
// tb/tb_out_stretch.sv - directed self-checking bench for out_stretch (HOLD=4 and HOLD=1 builds)
module tb_out_stretch;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic e1 = 1'b0, e2 = 1'b0, e3 = 1'b0;
  logic f1 = 1'b0, f2 = 1'b0, f3 = 1'b0;
  logic q1, q2, q3, any_active;
  logic p1, p2, p3, p_any;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  out_stretch #(.HOLD(4)) dut4 (
    .clk(clk), .reset(reset), .e1(e1), .e2(e2), .e3(e3),
    .q1(q1), .q2(q2), .q3(q3), .any_active(any_active)
  );

  out_stretch #(.HOLD(1)) dut1 (
    .clk(clk), .reset(reset), .e1(f1), .e2(f2), .e3(f3),
    .q1(p1), .q2(p2), .q3(p3), .any_active(p_any)
  );

  // observed vectors packed as {any_active, q3, q2, q1}
  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] v4();
    return {any_active, q3, q2, q1};
  endfunction

  function automatic logic [3:0] v1();
    return {p_any, p3, p2, p1};
  endfunction

  initial begin
    logic [6:0] retrig_exp;
    logic [3:0] b2b_in;
    #1;
    // reset then idle
    for (int i = 0; i < 2; i++) begin
      step();
      chk("reset_h4", v4(), 4'b0000);
      chk("reset_h1", v1(), 4'b0000);
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_h4", v4(), 4'b0000);
    end

    // single strobe on e1: high for 4 posedges then low
    e1 = 1'b1;
    step();
    e1 = 1'b0;
    chk("single_0", v4(), 4'b1001);
    for (int i = 1; i < 4; i++) begin
      step();
      chk("single_hi", v4(), 4'b1001);
    end
    step();
    chk("single_end", v4(), 4'b0000);

    // retrigger on e2 two cycles after first strobe: 6 high cycles
    retrig_exp = 7'b0111111;
    for (int i = 0; i < 7; i++) begin
      e2 = (i == 0 || i == 2);
      step();
      chk("retrig", v4(), retrig_exp[i] ? 4'b1010 : 4'b0000);
    end
    e2 = 1'b0;

    // e3 held across reset release must not fire
    e3 = 1'b1;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("held_level", v4(), 4'b0000);
    end
    e3 = 1'b0;
    step();
    chk("held_low", v4(), 4'b0000);
    e3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("held_pulse", v4(), 4'b1100);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      chk("held_after", v4(), 4'b0000);
    end
    e3 = 1'b0;
    step();

    // simultaneous strobes, then reset mid-stretch
    e1 = 1'b1;
    e2 = 1'b1;
    step();
    e1 = 1'b0;
    e2 = 1'b0;
    chk("simul", v4(), 4'b1011);
    reset = 1'b1;
    step();
    chk("mid_reset", v4(), 4'b0000);
    e1 = 1'b1;
    step();
    chk("strobe_in_reset", v4(), 4'b0000);
    reset = 1'b0;
    e1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_reset", v4(), 4'b0000);
    end

    // HOLD=1 build: one-cycle registered copy of each edge
    f1 = 1'b1;
    step();
    f1 = 1'b0;
    chk("h1_e1", v1(), 4'b1001);
    step();
    chk("h1_e1_off", v1(), 4'b0000);
    f3 = 1'b1;
    step();
    f3 = 1'b0;
    chk("h1_e3", v1(), 4'b1100);
    step();
    chk("h1_e3_off", v1(), 4'b0000);
    b2b_in = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      f2 = b2b_in[i];
      step();
      chk("h1_b2b", v1(), b2b_in[i] ? 4'b1010 : 4'b0000);
    end
    f2 = 1'b0;
    step();
    chk("h1_idle", v1(), 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
